// File: rtl/zinde_mem_loader.sv
// ZindeRV8 main memory: single-port RAM shared between a boot-time byte-stream
// loader and the CPU bus, plus the sequencer that holds the CPU in reset until it may run.
module zinde_mem_loader #(
    parameter int          ADDR_W    = 8,
    parameter int          DATA_W    = 8,
    parameter int unsigned LOAD_BASE = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load_start,
    input  logic              i_run_start,
    input  logic [ADDR_W-1:0] i_load_len,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic              i_load_valid,
    output logic              o_load_ready,
    input  logic [ADDR_W-1:0] i_cpu_address,
    input  logic [DATA_W-1:0] i_cpu_to_memory,
    input  logic              i_cpu_write,
    output logic [DATA_W-1:0] o_cpu_from_memory,
    output logic              o_cpu_rst,
    output logic              o_loading,
    output logic              o_load_done,
    output logic [DATA_W-1:0] o_load_checksum
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(LOAD_BASE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] r_len;
    logic              r_load_done;
    logic [DATA_W-1:0] r_checksum;
    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    logic              w_beat;
    logic              w_cpu_we;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic [ADDR_W-1:0] w_cnt_next;

    assign w_beat     = (r_state == ST_LOAD) && i_load_valid;
    assign w_cpu_we   = (r_state == ST_RUN) && i_cpu_write;
    assign w_cnt_next = r_cnt + ADDR_W'(1);

    // A len of 0 terminates when the counter wraps back to 0, i.e. after 2**ADDR_W beats.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= BASE;
            r_cnt       <= '0;
            r_len       <= '0;
            r_load_done <= 1'b0;
            r_checksum  <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_RUN: begin
                    if (i_load_start) begin
                        r_state     <= ST_LOAD;
                        r_len       <= i_load_len;
                        r_ptr       <= BASE;
                        r_cnt       <= '0;
                        r_checksum  <= '0;
                        r_load_done <= 1'b0;
                    end else if (i_run_start && (r_state == ST_IDLE)) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_LOAD: begin
                    if (i_load_valid) begin
                        r_ptr      <= r_ptr + ADDR_W'(1);
                        r_cnt      <= w_cnt_next;
                        r_checksum <= r_checksum + i_load_data;
                        if (w_cnt_next == r_len) begin
                            r_state     <= ST_RUN;
                            r_load_done <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The loader owns the write port outside RUN; reset suppresses any pending write.
    assign w_mem_we    = !i_rst && (w_beat || w_cpu_we);
    assign w_mem_addr  = w_beat ? r_ptr : i_cpu_address;
    assign w_mem_wdata = w_beat ? i_load_data : i_cpu_to_memory;

    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    assign o_cpu_from_memory = r_mem[i_cpu_address];
    assign o_cpu_rst         = i_rst || (r_state != ST_RUN);
    assign o_load_ready      = (r_state == ST_LOAD);
    assign o_loading         = o_load_ready;
    assign o_load_done       = r_load_done;
    assign o_load_checksum   = r_checksum;

endmodule

// File: tb/tb_zinde_mem_loader.sv
// Directed bench for zinde_mem_loader: one instance loads at base 0, a second at
// base 8'hFE to exercise address wrap; both see the same stimulus.
module tb_zinde_mem_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_start;
    logic       run_start;
    logic [7:0] load_len;
    logic [7:0] load_data;
    logic       load_valid;
    logic [7:0] cpu_address;
    logic [7:0] cpu_to_memory;
    logic       cpu_write;

    logic       m_ready, m_cpu_rst, m_loading, m_done;
    logic [7:0] m_rdata, m_cksum;
    logic       w_ready, w_cpu_rst, w_loading, w_done;
    logic [7:0] w_rdata, w_cksum;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    zinde_mem_loader #(.ADDR_W(8), .DATA_W(8), .LOAD_BASE(0)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_load_start(load_start), .i_run_start(run_start),
        .i_load_len(load_len), .i_load_data(load_data), .i_load_valid(load_valid),
        .o_load_ready(m_ready), .i_cpu_address(cpu_address), .i_cpu_to_memory(cpu_to_memory),
        .i_cpu_write(cpu_write), .o_cpu_from_memory(m_rdata), .o_cpu_rst(m_cpu_rst),
        .o_loading(m_loading), .o_load_done(m_done), .o_load_checksum(m_cksum)
    );

    zinde_mem_loader #(.ADDR_W(8), .DATA_W(8), .LOAD_BASE(8'hFE)) u_dut_wrap (
        .i_clk(clk), .i_rst(rst), .i_load_start(load_start), .i_run_start(run_start),
        .i_load_len(load_len), .i_load_data(load_data), .i_load_valid(load_valid),
        .o_load_ready(w_ready), .i_cpu_address(cpu_address), .i_cpu_to_memory(cpu_to_memory),
        .i_cpu_write(cpu_write), .o_cpu_from_memory(w_rdata), .o_cpu_rst(w_cpu_rst),
        .o_loading(w_loading), .o_load_done(w_done), .o_load_checksum(w_cksum)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_load(input logic [7:0] len);
        load_start = 1'b1;
        load_len   = len;
        @(posedge clk); #1;
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int stalls);
        load_valid = 1'b0;
        repeat (stalls) begin
            @(posedge clk); #1;
        end
        load_valid = 1'b1;
        load_data  = b;
        @(posedge clk); #1;
        load_valid = 1'b0;
    endtask

    task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_address   = a;
        cpu_to_memory = d;
        cpu_write     = 1'b1;
        @(posedge clk); #1;
        cpu_write = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
        @(negedge clk);
        cpu_address = a;
        #1;
        chk(tag, m_rdata, exp);
    endtask

    task automatic rd_w(input string tag, input logic [7:0] a, input logic [7:0] exp);
        @(negedge clk);
        cpu_address = a;
        #1;
        chk(tag, w_rdata, exp);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load_start = 1'b0; run_start = 1'b0; load_len = '0;
        load_data = '0; load_valid = 1'b0; cpu_address = '0; cpu_to_memory = '0; cpu_write = 1'b0;

        // 1: reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cpu_rst", m_cpu_rst, 1);
        chk("rst_ready", m_ready, 0);
        chk("rst_loading", m_loading, 0);
        chk("rst_done", m_done, 0);
        chk("rst_cksum", m_cksum, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_cpu_rst", m_cpu_rst, 1);

        // 2: back-to-back load of four bytes
        start_load(8'd4);
        @(negedge clk);
        chk("s2_ready", m_ready, 1);
        chk("s2_loading", m_loading, 1);
        send_byte(8'h10, 0);
        send_byte(8'h20, 0);
        send_byte(8'h30, 0);
        load_valid = 1'b1;
        load_data  = 8'hF0;
        @(negedge clk);
        chk("s2_cpu_rst_last_beat", m_cpu_rst, 1);
        chk("s2_done_last_beat", m_done, 0);
        @(posedge clk); #1;
        load_valid = 1'b0;
        @(negedge clk);
        chk("s2_cpu_rst_after", m_cpu_rst, 0);
        chk("s2_done", m_done, 1);
        chk("s2_cksum", m_cksum, 8'h50);
        chk("s2_ready_after", m_ready, 0);
        rd("s2_mem0", 8'h00, 8'h10);
        rd("s2_mem1", 8'h01, 8'h20);
        rd("s2_mem2", 8'h02, 8'h30);
        rd("s2_mem3", 8'h03, 8'hF0);

        // 3: reload from RUN with stalls; mem[2] scribbled first so the reload is visible
        cpu_wr(8'h02, 8'h00);
        rd("s3_pre_mem2", 8'h02, 8'h00);
        start_load(8'd4);
        @(negedge clk);
        chk("s3_cpu_rst_reload", m_cpu_rst, 1);
        chk("s3_done_cleared", m_done, 0);
        chk("s3_cksum_cleared", m_cksum, 0);
        run_start = 1'b1;
        @(posedge clk); #1;
        run_start = 1'b0;
        @(negedge clk);
        chk("s3_run_ignored", m_loading, 1);
        send_byte(8'h10, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("s3_stall_cksum", m_cksum, 8'h10);
        chk("s3_stall_loading", m_loading, 1);
        @(posedge clk); #1;
        send_byte(8'h20, 0);
        send_byte(8'h30, 2);
        send_byte(8'hF0, 2);
        @(negedge clk);
        chk("s3_done", m_done, 1);
        chk("s3_cksum", m_cksum, 8'h50);
        chk("s3_cpu_rst", m_cpu_rst, 0);
        rd("s3_mem2", 8'h02, 8'h30);
        rd("s3_mem3", 8'h03, 8'hF0);

        // 4: CPU writes in RUN, ignored in IDLE; RAM survives reset
        cpu_wr(8'h80, 8'hA5);
        rd("s4_mem80", 8'h80, 8'hA5);
        cpu_wr(8'h81, 8'h11);
        rd("s4_mem81", 8'h81, 8'h11);
        pulse_rst();
        cpu_wr(8'h81, 8'h5A);
        rd("s4_idle_write_ignored", 8'h81, 8'h11);
        rd("s4_mem80_kept", 8'h80, 8'hA5);
        chk("s4_idle_cpu_rst", m_cpu_rst, 1);
        chk("s4_rst_done", m_done, 0);

        // 5: load_start and run_start together; wrapping instance at base 8'hFE
        @(negedge clk);
        load_start = 1'b1;
        run_start  = 1'b1;
        load_len   = 8'd3;
        @(posedge clk); #1;
        load_start = 1'b0;
        run_start  = 1'b0;
        @(negedge clk);
        chk("s5_load_wins", w_loading, 1);
        chk("s5_cpu_rst", w_cpu_rst, 1);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        @(negedge clk);
        chk("s5_done", w_done, 1);
        chk("s5_cksum", w_cksum, 8'h06);
        chk("s5_cpu_rst_after", w_cpu_rst, 0);
        rd_w("s5_memFE", 8'hFE, 8'h01);
        rd_w("s5_memFF", 8'hFF, 8'h02);
        rd_w("s5_mem00", 8'h00, 8'h03);
        rd("s5_main_mem2", 8'h02, 8'h03);

        // 6: reset after two beats, with a beat pending on the reset cycle
        pulse_rst();
        start_load(8'd4);
        cpu_address   = 8'h81;
        cpu_to_memory = 8'hEE;
        cpu_write     = 1'b1;
        send_byte(8'h61, 0);
        send_byte(8'h62, 0);
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = 8'h63;
        rst        = 1'b1;
        @(posedge clk); #1;
        rst        = 1'b0;
        load_valid = 1'b0;
        cpu_write  = 1'b0;
        @(negedge clk);
        chk("s6_ready", m_ready, 0);
        chk("s6_done", m_done, 0);
        chk("s6_cpu_rst", m_cpu_rst, 1);
        chk("s6_cksum", m_cksum, 0);
        run_start = 1'b1;
        @(posedge clk); #1;
        run_start = 1'b0;
        @(negedge clk);
        chk("s6_run", m_cpu_rst, 0);
        rd("s6_mem0", 8'h00, 8'h61);
        rd("s6_mem1", 8'h01, 8'h62);
        rd("s6_pending_not_written", 8'h02, 8'h03);
        rd("s6_load_cpu_write_ignored", 8'h81, 8'h11);

        // 7: len 0 means a full 256-byte load
        start_load(8'd0);
        for (int i = 0; i < 255; i++) send_byte(8'(i), 0);
        @(negedge clk);
        chk("s7_still_loading", m_ready, 1);
        chk("s7_not_done", m_done, 0);
        send_byte(8'hFF, 0);
        @(negedge clk);
        chk("s7_done", m_done, 1);
        chk("s7_cksum", m_cksum, 8'h80);
        chk("s7_cpu_rst", m_cpu_rst, 0);
        chk("s7_wrap_cksum", w_cksum, 8'h80);
        rd("s7_mem00", 8'h00, 8'h00);
        rd("s7_mem80", 8'h80, 8'h80);
        rd("s7_memFF", 8'hFF, 8'hFF);
        rd_w("s7_wrap_memFE", 8'hFE, 8'h00);
        rd_w("s7_wrap_mem01", 8'h01, 8'h03);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
